// File: rtl/timestamp_frame_arbiter.sv
// Round-robin, frame-locked merger of CHANNELS timestamp source FIFOs into one
// pull-style FIFO interface, with frame sequencing checks, stall recovery and
// status counters.
module timestamp_frame_arbiter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned FRAME_WORDS = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic [CHANNELS-1:0]      CHANNEL_EN,
  input  logic [CHANNELS-1:0]      SRC_FIFO_EMPTY,
  input  logic [32*CHANNELS-1:0]   SRC_FIFO_DATA,
  output logic [CHANNELS-1:0]      SRC_FIFO_READ,
  input  logic                     FIFO_READ,
  output logic                     FIFO_EMPTY,
  output logic [31:0]              FIFO_DATA,
  output logic [3:0]               GRANT,
  output logic [31:0]              FRAME_CNT,
  output logic [7:0]               SYNC_ERR_CNT,
  output logic [7:0]               TIMEOUT_CNT
);

  localparam int unsigned DW  = 32;
  localparam int unsigned GW  = 4;
  localparam int unsigned IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned WCW = 4;
  localparam int unsigned SW  = 8;
  localparam int unsigned CW  = 8;
  localparam int unsigned FW  = 32;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [CW-1:0]   sync_q, sync_d;
  logic [CW-1:0]   tmo_q, tmo_d;

  logic [CHANNELS-1:0] cand;
  logic                rr_found;
  logic [IW-1:0]       rr_pick;
  logic [IW-1:0]       gidx;
  logic                g_empty;
  logic [DW-1:0]       g_data;
  logic [3:0]          nib;
  logic                accept;
  logic [SW-1:0]       stall_inc;

  assign cand      = CHANNEL_EN & ~SRC_FIFO_EMPTY;
  assign gidx      = grant_q[IW-1:0];
  assign nib       = g_data[27:24];
  assign accept    = (state_q == S_LOCKED) && FIFO_READ && !g_empty;
  assign stall_inc = stall_q + SW'(1);

  // Round-robin pick: first candidate above last_grant, else wrap from channel 0
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!rr_found && cand[i] && (IW'(i) > last_q)) begin
        rr_found = 1'b1;
        rr_pick  = IW'(i);
      end
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!rr_found && cand[i] && (IW'(i) <= last_q)) begin
        rr_found = 1'b1;
        rr_pick  = IW'(i);
      end
    end
  end

  // Select the empty flag and data word of the granted source
  always_comb begin
    g_empty = 1'b1;
    g_data  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (gidx == IW'(i)) begin
        g_empty = SRC_FIFO_EMPTY[i];
        g_data  = SRC_FIFO_DATA[DW*i +: DW];
      end
    end
  end

  // State and status registers
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= IW'(CHANNELS - 1);
      word_cnt_q <= '0;
      stall_q    <= '0;
      frame_q    <= '0;
      sync_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      stall_q    <= stall_d;
      frame_q    <= frame_d;
      sync_q     <= sync_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state: arbitration, frame sequencing and stall timeout
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    stall_d    = stall_q;
    frame_d    = frame_q;
    sync_d     = sync_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_d    = GW'(rr_pick);
          state_d    = S_LOCKED;
          word_cnt_d = '0;
          stall_d    = '0;
        end
      end
      S_LOCKED: begin
        if (accept) begin
          stall_d = '0;
          if (nib == WCW'(word_cnt_q + WCW'(1))) begin
            if (word_cnt_q == WCW'(FRAME_WORDS - 1)) begin
              state_d    = S_IDLE;
              last_d     = gidx;
              word_cnt_d = '0;
              frame_d    = frame_q + FW'(1);
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
            end
          end else begin
            // Mismatch: a new frame head resyncs in place, anything else drops the lock
            if (sync_q != {CW{1'b1}}) sync_d = sync_q + CW'(1);
            if (nib == 4'd1) begin
              word_cnt_d = WCW'(1);
            end else begin
              state_d    = S_IDLE;
              last_d     = gidx;
              word_cnt_d = '0;
            end
          end
        end else if (g_empty) begin
          if (stall_inc == SW'(TIMEOUT)) begin
            state_d    = S_IDLE;
            last_d     = gidx;
            word_cnt_d = '0;
            stall_d    = '0;
            if (tmo_q != {CW{1'b1}}) tmo_d = tmo_q + CW'(1);
          end else begin
            stall_d = stall_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: pass-through of the granted source while locked, idle/empty otherwise
  always_comb begin
    FIFO_EMPTY    = 1'b1;
    FIFO_DATA     = '0;
    SRC_FIFO_READ = '0;
    if (state_q == S_LOCKED) begin
      FIFO_EMPTY = g_empty;
      FIFO_DATA  = g_data;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        SRC_FIFO_READ[i] = accept && (gidx == IW'(i));
      end
    end
  end

  assign GRANT        = grant_q;
  assign FRAME_CNT    = frame_q;
  assign SYNC_ERR_CNT = sync_q;
  assign TIMEOUT_CNT  = tmo_q;

endmodule

// File: tb/tb_timestamp_frame_arbiter.sv
// Bench for timestamp_frame_arbiter: source FIFOs are bench queues, a
// transaction-level reference predicts every output each cycle.
module tb_timestamp_frame_arbiter;

  localparam int CH = 4;
  localparam int FW = 3;
  localparam int TO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CH-1:0]     en;
  logic [CH-1:0]     empty_v;
  logic [32*CH-1:0]  data_v;
  logic [CH-1:0]     src_rd;
  logic              rd;
  logic              f_empty;
  logic [31:0]       f_data;
  logic [3:0]        grant;
  logic [31:0]       frame_cnt;
  logic [7:0]        sync_cnt;
  logic [7:0]        tmo_cnt;

  timestamp_frame_arbiter #(.CHANNELS(CH), .FRAME_WORDS(FW), .TIMEOUT(TO)) dut (
    .BUS_CLK        (clk),
    .BUS_RST_N      (rst_n),
    .CHANNEL_EN     (en),
    .SRC_FIFO_EMPTY (empty_v),
    .SRC_FIFO_DATA  (data_v),
    .SRC_FIFO_READ  (src_rd),
    .FIFO_READ      (rd),
    .FIFO_EMPTY     (f_empty),
    .FIFO_DATA      (f_data),
    .GRANT          (grant),
    .FRAME_CNT      (frame_cnt),
    .SYNC_ERR_CNT   (sync_cnt),
    .TIMEOUT_CNT    (tmo_cnt)
  );

  // Source FIFO contents and scenario controls (applied to the DUT at negedge)
  logic [31:0] srcq [CH][$];
  bit          hold [CH];
  logic        s_rst_n;
  logic [CH-1:0] s_en;
  logic        s_rd;
  int          seq;

  // Reference model: who owns the output, position inside the frame, counters
  bit          m_locked;
  int          m_owner, m_last, m_pos, m_stall, m_sync, m_tmo;
  logic [31:0] m_frames;
  logic [31:0] m_out [$];

  // Snapshot of DUT outputs taken at the last compare point
  logic        sn_empty;
  logic [CH-1:0] sn_rd;
  logic [3:0]  sn_grant;
  logic [31:0] sn_frame;
  logic [7:0]  sn_sync, sn_tmo;

  int n_cmp, n_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_last = CH - 1; m_pos = 0; m_stall = 0;
    m_frames = 0; m_sync = 0; m_tmo = 0;
  endtask

  task automatic model_release();
    m_locked = 0; m_last = m_owner; m_pos = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs the DUT saw
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (!m_locked) begin
      bit found = 0;
      for (int k = 1; k <= CH; k++) begin
        int c = (m_last + k) % CH;
        if (!found && en[c] && !empty_v[c]) begin
          found = 1; m_owner = c; m_locked = 1; m_pos = 0; m_stall = 0;
        end
      end
    end else begin
      bit          hd = empty_v[m_owner];
      logic [31:0] w  = data_v[32*m_owner +: 32];
      int          nb = int'(w[27:24]);
      if (rd && !hd) begin
        m_out.push_back(w);
        m_stall = 0;
        if (nb == m_pos + 1) begin
          m_pos++;
          if (m_pos == FW) begin
            m_frames++;
            model_release();
          end
        end else begin
          if (m_sync < 255) m_sync++;
          if (nb == 1) m_pos = 1;
          else model_release();
        end
      end else if (hd) begin
        m_stall++;
        if (m_stall == TO) begin
          if (m_tmo < 255) m_tmo++;
          m_stall = 0;
          model_release();
        end
      end
    end
  endtask

  task automatic drive_inputs();
    rst_n = s_rst_n;
    en    = s_en;
    rd    = s_rd;
    for (int i = 0; i < CH; i++) begin
      empty_v[i] = (srcq[i].size() == 0) || hold[i];
      data_v[32*i +: 32] = (srcq[i].size() > 0) ? srcq[i][0] : (32'hE0EE_0000 | 32'(i));
    end
  endtask

  task automatic compare_outputs();
    logic          e_empty;
    logic [31:0]   e_data;
    logic [CH-1:0] e_rd;
    e_empty = 1'b1;
    e_data  = '0;
    e_rd    = '0;
    if (m_locked) begin
      e_empty = empty_v[m_owner];
      e_data  = data_v[32*m_owner +: 32];
      if (rd && !empty_v[m_owner]) e_rd[m_owner] = 1'b1;
    end
    check("fifo_empty", 32'(f_empty), 32'(e_empty));
    check("fifo_data", f_data, e_data);
    check("src_read", 32'(src_rd), 32'(e_rd));
    check("grant", 32'(grant), 32'(m_owner));
    check("frame_cnt", frame_cnt, m_frames);
    check("sync_err_cnt", 32'(sync_cnt), 32'(m_sync));
    check("timeout_cnt", 32'(tmo_cnt), 32'(m_tmo));
    sn_empty = f_empty; sn_rd = src_rd; sn_grant = grant;
    sn_frame = frame_cnt; sn_sync = sync_cnt; sn_tmo = tmo_cnt;
  endtask

  task automatic cycle();
    logic [CH-1:0] rd_cap;
    @(negedge clk);
    drive_inputs();
    #1;
    compare_outputs();
    rd_cap = src_rd;
    @(posedge clk);
    model_step();
    for (int i = 0; i < CH; i++)
      if (rd_cap[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic push_word(int ch, int nb);
    srcq[ch].push_back({4'(ch), 4'(nb), 24'(seq)});
    seq++;
  endtask

  task automatic push_frame(int ch);
    for (int w = 1; w <= FW; w++) push_word(ch, w);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < CH; i++) begin
      srcq[i].delete();
      hold[i] = 0;
    end
  endtask

  task automatic do_reset();
    s_rst_n = 0; s_rd = 0;
    run(2);
    clear_sources();
    m_out.delete();
    s_rst_n = 1; s_en = '1;
  endtask

  // Checks that the accepted-word log carries the given channel sequence in order
  function automatic bit order_ok(int chs[$]);
    if (m_out.size() != chs.size()) return 0;
    foreach (chs[j]) if (int'(m_out[j][31:28]) != chs[j]) return 0;
    return 1;
  endfunction

  initial begin
    int exp_ch[$];
    bit ok;
    n_cmp = 0; n_err = 0; seq = 0;
    clear_sources();
    model_reset();
    s_rst_n = 0; s_en = '1; s_rd = 0;
    drive_inputs();

    // Reset then idle
    run(2);
    check("rst_empty", 32'(sn_empty), 32'd1);
    check("rst_src_read", 32'(sn_rd), 32'd0);
    check("rst_grant", 32'(sn_grant), 32'd0);
    check("rst_frame", sn_frame, 32'd0);
    check("rst_sync", 32'(sn_sync), 32'd0);
    check("rst_tmo", 32'(sn_tmo), 32'd0);
    s_rst_n = 1;
    push_frame(0);
    run(2);
    check("first_grant", 32'(sn_grant), 32'd0);
    check("first_locked", 32'(sn_empty), 32'd0);
    s_rd = 1;
    run(6);
    check("first_frame", sn_frame, 32'd1);

    // Fairness: two frames per channel, read held high
    do_reset();
    for (int r = 0; r < 2; r++) for (int c = 0; c < CH; c++) push_frame(c);
    s_rd = 1;
    run(40);
    check("fair_frames", sn_frame, 32'd8);
    check("fair_sync", 32'(sn_sync), 32'd0);
    exp_ch.delete();
    for (int j = 0; j < 24; j++) exp_ch.push_back((j / 3) % CH);
    ok = order_ok(exp_ch);
    for (int j = 0; j < 24 && ok; j++) if (int'(m_out[j][27:24]) != (j % 3) + 1) ok = 0;
    check("fair_order", 32'(ok), 32'd1);

    // Stall timeout on ch1 with ch2 waiting
    do_reset();
    push_word(1, 1); push_word(1, 2);
    push_frame(2);
    s_rd = 1;
    run(258);
    check("tmo_before", 32'(sn_tmo), 32'd0);
    run(1);
    check("tmo_after", 32'(sn_tmo), 32'd1);
    check("tmo_frame_unch", sn_frame, 32'd0);
    run(8);
    check("tmo_next_grant", 32'(sn_grant), 32'd2);
    check("tmo_ch2_frame", sn_frame, 32'd1);
    exp_ch = '{1, 1, 2, 2, 2};
    check("tmo_order", 32'(order_ok(exp_ch)), 32'd1);

    // Resync on a repeated frame head
    do_reset();
    push_word(0, 1); push_word(0, 1); push_word(0, 2); push_word(0, 3);
    s_rd = 1;
    run(8);
    check("resync_sync", 32'(sn_sync), 32'd1);
    check("resync_frame", sn_frame, 32'd1);
    check("resync_words", 32'(m_out.size()), 32'd4);

    // Bad nibble releases ch0, ch1 next
    do_reset();
    push_word(0, 1); push_word(0, 3);
    push_frame(1);
    s_rd = 1;
    run(10);
    check("bad_sync", 32'(sn_sync), 32'd1);
    check("bad_frame", sn_frame, 32'd1);
    exp_ch = '{0, 0, 1, 1, 1};
    check("bad_order", 32'(order_ok(exp_ch)), 32'd1);

    // Enable cleared mid-frame, then reset mid-frame
    do_reset();
    push_frame(2);
    s_rd = 1;
    run(2);
    s_en = 4'b1011;
    run(5);
    check("en_clear_frame", sn_frame, 32'd1);
    check("en_clear_words", 32'(m_out.size()), 32'd3);
    s_en = '1;
    push_frame(3);
    run(3);
    s_rst_n = 0; s_rd = 0;
    run(2);
    check("midrst_src_read", 32'(sn_rd), 32'd0);
    check("midrst_empty", 32'(sn_empty), 32'd1);
    check("midrst_frame", sn_frame, 32'd0);
    check("midrst_sync", 32'(sn_sync), 32'd0);
    clear_sources();
    s_rst_n = 1;
    run(2);

    // Randomized traffic with corrupted nibbles, stalls and enable changes
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      s_rd = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 49) == 0) s_en[c] = ~s_en[c];
        if (!hold[c] && $urandom_range(0, 399) == 0) hold[c] = 1;
        else if (hold[c] && $urandom_range(0, 299) == 0) hold[c] = 0;
        if (srcq[c].size() < 6 && $urandom_range(0, 7) == 0) begin
          for (int w = 1; w <= FW; w++)
            push_word(c, ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 15)) : w);
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timestamp_frame_arbiter.md
Name: timestamp_frame_arbiter

Overview:
Merges the 32-bit output FIFOs of up to CHANNELS timestamp/TDC cores into one pull-style FIFO interface for the readout.
Each core emits fixed 3-word frames, marked by a word-index nibble in bits 27:24 = 1, 2, 3. The arbiter grants one channel at a time, round-robin, and holds the grant until a whole frame has passed, so frames are never interleaved.
It checks frame sequencing, recovers from stalled or misaligned sources, and exposes status counters for the register block.

Parameters:
CHANNELS, 4, number of source FIFOs (2..16)
FRAME_WORDS, 3, words per frame; expected index nibble of word k is k+1
TIMEOUT, 255, max stalled cycles mid-frame before the grant is released (1..255)

Ports:
BUS_CLK  in  1  single clock for all logic
BUS_RST_N  in  1  reset, synchronous, active-low
CHANNEL_EN  in  CHANNELS  per-channel arbitration enable
SRC_FIFO_EMPTY  in  CHANNELS  source empty flags
SRC_FIFO_DATA  in  32*CHANNELS  source data; channel i occupies [32*i+31:32*i]
SRC_FIFO_READ  out  CHANNELS  source read strobes; at most one bit high
FIFO_READ  in  1  downstream read request
FIFO_EMPTY  out  1  merged empty flag
FIFO_DATA  out  32  merged data, combinational from the granted source
GRANT  out  4  index of the granted channel
FRAME_CNT  out  32  completed frames, wraps
SYNC_ERR_CNT  out  8  index-nibble mismatches, saturates at 255
TIMEOUT_CNT  out  8  timeout releases, saturates at 255

Behaviour:
- Two-state FSM: IDLE and LOCKED. Registers: state, grant, last_grant, word_cnt, stall_cnt and the three counters.
- Reset is sampled at a BUS_CLK edge with BUS_RST_N=0. It overrides everything, including mid-frame activity. Reset values:
  - state=IDLE, grant=0, last_grant=CHANNELS-1, word_cnt=0, stall_cnt=0.
  - All counters = 0.
  - Outputs: FIFO_EMPTY=1, SRC_FIFO_READ=0, FIFO_DATA=0.
- IDLE behaviour:
  - Outputs: FIFO_EMPTY=1, SRC_FIFO_READ=0, FIFO_DATA=0.
  - Candidates are channels with CHANNEL_EN=1 and SRC_FIFO_EMPTY=0.
  - If any candidate exists, the first one searched from last_grant+1 upward (modulo CHANNELS) is registered into grant.
  - Next state is LOCKED with word_cnt=0 and stall_cnt=0. Arbitration latency is exactly 1 cycle.
- LOCKED outputs (all combinational):
  - FIFO_EMPTY = SRC_FIFO_EMPTY[grant].
  - FIFO_DATA = granted word.
  - SRC_FIFO_READ[grant] = FIFO_READ & ~SRC_FIFO_EMPTY[grant]; all other bits are 0.
- FIFO_READ while FIFO_EMPTY=1 is ignored: no strobe and no state change.
- Accepted read (FIFO_READ & ~FIFO_EMPTY in LOCKED), with nib = FIFO_DATA[27:24]:
  - nib == word_cnt+1: word_cnt increments. If word_cnt was FRAME_WORDS-1, then state→IDLE, last_grant←grant, FRAME_CNT+1.
  - nib ≠ word_cnt+1 and nib == 1: SYNC_ERR_CNT+1, word_cnt←1, stay LOCKED. This resyncs onto a new frame head.
  - Any other mismatch: SYNC_ERR_CNT+1, state→IDLE, last_grant←grant, FRAME_CNT unchanged.
  - In every case the word is still delivered downstream unchanged.
- Stall handling:
  - In LOCKED, stall_cnt←0 on any accepted read. Otherwise stall_cnt increments while SRC_FIFO_EMPTY[grant]=1.
  - When stall_cnt reaches TIMEOUT: state→IDLE, last_grant←grant, TIMEOUT_CNT+1, stall_cnt←0.
  - A read accepted in the same cycle that TIMEOUT would be reached takes priority; no timeout is counted.
- Clearing CHANNEL_EN of the granted channel mid-frame does not break the lock; the frame completes or times out.
- Single enabled channel: back-to-back frames from it cost one IDLE cycle between frames.
- Saturating counters hold at 255. FRAME_CNT wraps 2^32-1 → 0.
- If FRAME_WORDS=1 the frame completes on every accepted read.

Test Plan:
- Reset then idle: BUS_RST_N=0 for 2 cycles with all sources empty → FIFO_EMPTY=1, SRC_FIFO_READ=0, GRANT=0, all counters 0. After release, ch0 gets 3 words → GRANT=0 one cycle later.
- Fairness: ch0..ch3 each hold 2 valid frames, FIFO_READ held high → output order is ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3, 3 words each, never interleaved. FRAME_CNT=8 and SYNC_ERR_CNT=0 at the end.
- Stall timeout: ch1 supplies words with nibbles 1,2 then goes empty, TIMEOUT=255 → after 255 empty cycles TIMEOUT_CNT=1 and state returns to IDLE. A pending ch2 frame is granted next. FRAME_CNT unchanged.
- Resync: ch0 supplies nibbles 1,1,2,3 → SYNC_ERR_CNT=1, FRAME_CNT=1, all 4 words delivered.
- Bad nibble: ch0 supplies nibbles 1,3 → SYNC_ERR_CNT=1 and ch0 is released after the 2nd word. Next grant goes to ch1 if pending.
- Mid-frame effects:
  - CHANNEL_EN[2] is cleared after word 1 of a ch2 frame → the remaining 2 words are still delivered.
  - BUS_RST_N is pulsed low after word 2 of a later frame → state returns to IDLE, SRC_FIFO_READ=0 and all counters are cleared in the same cycle.
